// File: rtl/ceespu_dmem_bridge_pkg.sv
// Shared types and constants for the ceespu data-memory bridge.
package ceespu_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } dmem_state_t;

    localparam int unsigned DMEM_BUS_REGION_BIT = 15;
    localparam logic [31:0] DMEM_ERR_DATA       = 32'hDEADBEEF;

endpackage

// File: rtl/ceespu_dmem_bridge_if.sv
// Peripheral bus seen from the bridge (master) and from the peripheral (slave).
interface ceespu_dmem_bridge_if;

    logic        O_busReq;
    logic [14:0] O_busAddr;
    logic [31:0] O_busWData;
    logic [3:0]  O_busWe;
    logic        I_busAck;
    logic [31:0] I_busRData;
    logic        O_busErr;

    modport master (
        output O_busReq, O_busAddr, O_busWData, O_busWe, O_busErr,
        input  I_busAck, I_busRData
    );

    modport slave (
        input  O_busReq, O_busAddr, O_busWData, O_busWe, O_busErr,
        output I_busAck, I_busRData
    );

endinterface

// File: rtl/ceespu_dmem_bridge_bus_timeout.sv
// Ack wait counter for the bridge; built only when CEESPU_DMEM_TIMEOUT_EN is defined.
module ceespu_bus_timeout #(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic I_clk,
    input  logic I_rst,
    input  logic I_clear,
    input  logic I_inc,
    output logic O_expired
);

    localparam logic [7:0] LIMIT = 8'(TIMEOUT_CYCLES);

    logic [7:0] cnt_q;
    logic [7:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (I_clear) begin
            cnt_d = '0;
        end else if (I_inc) begin
            cnt_d = cnt_q + 8'd1;
        end
    end

    always_ff @(posedge I_clk or posedge I_rst) begin
        if (I_rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign O_expired = (cnt_q == LIMIT);

endmodule

// File: rtl/ceespu_dmem_bridge.sv
// Core data-port bridge: addr[15]=0 goes to single-cycle BRAM, addr[15]=1 to the
// req/ack peripheral bus. Optional ack timeout under CEESPU_DMEM_TIMEOUT_EN.
module ceespu_dmem_bridge
    import ceespu_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic                 I_clk,
    input  logic                 I_rst,
    input  logic [15:0]          I_dmemAddress,
    input  logic [31:0]          I_dmemWData,
    input  logic                 I_dmemE,
    input  logic [3:0]           I_dmemWe,
    output logic [31:0]          O_dmemData,
    output logic                 O_dmemBusy,
    output logic [13:0]          O_ramAddr,
    output logic [31:0]          O_ramWData,
    output logic                 O_ramE,
    output logic [3:0]           O_ramWe,
    input  logic [31:0]          I_ramData,
    ceespu_dmem_bridge_if.master bus
);

    dmem_state_t state_q;
    logic        busReq_q;
    logic [14:0] busAddr_q;
    logic [31:0] busWData_q;
    logic [3:0]  busWe_q;
    logic [31:0] rdata_q;
    logic        sel_bus_q;

    logic bus_hit;
    logic in_wait;
    logic timeout;
    logic complete;

    assign bus_hit  = I_dmemE & I_dmemAddress[DMEM_BUS_REGION_BIT];
    assign in_wait  = (state_q == WAIT);
    assign complete = in_wait & (bus.I_busAck | timeout);

    assign O_ramAddr  = I_dmemAddress[15:2];
    assign O_ramWData = I_dmemWData;
    assign O_ramE     = I_dmemE & ~I_dmemAddress[DMEM_BUS_REGION_BIT];
    assign O_ramWe    = O_ramE ? I_dmemWe : 4'b0000;

    assign O_dmemBusy = (~in_wait & bus_hit) | (in_wait & ~bus.I_busAck & ~timeout);
    assign O_dmemData = sel_bus_q ? rdata_q : I_ramData;

    assign bus.O_busReq   = busReq_q;
    assign bus.O_busAddr  = busAddr_q;
    assign bus.O_busWData = busWData_q;
    assign bus.O_busWe    = busWe_q;

`ifdef CEESPU_DMEM_TIMEOUT_EN
    logic expired;
    logic busErr_q;

    ceespu_bus_timeout #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_timeout (
        .I_clk    (I_clk),
        .I_rst    (I_rst),
        .I_clear  (~in_wait & bus_hit),
        .I_inc    (in_wait),
        .O_expired(expired)
    );

    assign timeout = in_wait & expired;

    // An ack arriving in the expiry cycle wins, so the error flag stays clear.
    always_ff @(posedge I_clk or posedge I_rst) begin
        if (I_rst) begin
            busErr_q <= 1'b0;
        end else if (timeout & ~bus.I_busAck) begin
            busErr_q <= 1'b1;
        end
    end

    assign bus.O_busErr = busErr_q;
`else
    assign timeout      = 1'b0;
    assign bus.O_busErr = 1'b0;
`endif

    always_ff @(posedge I_clk or posedge I_rst) begin
        if (I_rst) begin
            state_q    <= IDLE;
            busReq_q   <= 1'b0;
            busAddr_q  <= '0;
            busWData_q <= '0;
            busWe_q    <= '0;
            rdata_q    <= '0;
            sel_bus_q  <= 1'b0;
        end else begin
            case (state_q)
                WAIT: begin
                    if (complete) begin
                        state_q   <= RESP;
                        busReq_q  <= 1'b0;
                        rdata_q   <= bus.I_busAck ? bus.I_busRData : DMEM_ERR_DATA;
                        sel_bus_q <= 1'b1;
                    end
                end
                default: begin
                    // RESP accepts a new request exactly like IDLE.
                    if (bus_hit) begin
                        state_q    <= WAIT;
                        busReq_q   <= 1'b1;
                        busAddr_q  <= I_dmemAddress[14:0];
                        busWData_q <= I_dmemWData;
                        busWe_q    <= I_dmemWe;
                    end else begin
                        state_q <= IDLE;
                    end
                    if (O_ramE) begin
                        sel_bus_q <= 1'b0;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ceespu_dmem_bridge.sv
// Directed bench for ceespu_dmem_bridge; timeout steps run only with CEESPU_DMEM_TIMEOUT_EN.
module tb_ceespu_dmem_bridge;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [15:0] dmem_addr = '0;
    logic [31:0] dmem_wdata = '0;
    logic        dmem_e = 1'b0;
    logic [3:0]  dmem_we = '0;
    logic [31:0] dmem_data;
    logic        dmem_busy;
    logic [13:0] ram_addr;
    logic [31:0] ram_wdata;
    logic        ram_e;
    logic [3:0]  ram_we;
    logic [31:0] ram_rdata = '0;
    logic [31:0] mem [0:255];

    int unsigned n_checks = 0;
    int unsigned n_fail   = 0;

    ceespu_dmem_bridge_if bus_if ();

    always #5 clk = ~clk;

`ifdef CEESPU_DMEM_TIMEOUT_EN
    ceespu_dmem_bridge #(.TIMEOUT_CYCLES(4)) dut (
`else
    ceespu_dmem_bridge dut (
`endif
        .I_clk        (clk),
        .I_rst        (rst),
        .I_dmemAddress(dmem_addr),
        .I_dmemWData  (dmem_wdata),
        .I_dmemE      (dmem_e),
        .I_dmemWe     (dmem_we),
        .O_dmemData   (dmem_data),
        .O_dmemBusy   (dmem_busy),
        .O_ramAddr    (ram_addr),
        .O_ramWData   (ram_wdata),
        .O_ramE       (ram_e),
        .O_ramWe      (ram_we),
        .I_ramData    (ram_rdata),
        .bus          (bus_if.master)
    );

    // Synchronous BRAM with one-cycle read latency, read-before-write.
    always @(posedge clk) begin
        if (ram_e) begin
            ram_rdata <= mem[ram_addr[7:0]];
            for (int b = 0; b < 4; b++) begin
                if (ram_we[b]) mem[ram_addr[7:0]][8*b +: 8] <= ram_wdata[8*b +: 8];
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        @(negedge clk);
    endtask

    task automatic drive(input logic e, input logic [15:0] a, input logic [3:0] we, input logic [31:0] wd);
        dmem_e     = e;
        dmem_addr  = a;
        dmem_we    = we;
        dmem_wdata = wd;
    endtask

    initial begin
        bus_if.I_busAck   = 1'b0;
        bus_if.I_busRData = '0;

        // Reset values
        tick(); tick(); settle();
        chk("rst_busReq",   32'(bus_if.O_busReq),   32'h0);
        chk("rst_busAddr",  32'(bus_if.O_busAddr),  32'h0);
        chk("rst_busWData", bus_if.O_busWData,      32'h0);
        chk("rst_busWe",    32'(bus_if.O_busWe),    32'h0);
        chk("rst_busErr",   32'(bus_if.O_busErr),   32'h0);
        chk("rst_busy",     32'(dmem_busy),         32'h0);
        chk("rst_data",     dmem_data,              32'h0);
        tick(); rst = 1'b0;

        // RAM round trip
        tick(); drive(1'b1, 16'h0010, 4'hF, 32'h12345678); settle();
        chk("ramw_busy",  32'(dmem_busy), 32'h0);
        chk("ramw_ramE",  32'(ram_e),     32'h1);
        chk("ramw_ramWe", 32'(ram_we),    32'hF);
        chk("ramw_addr",  32'(ram_addr),  32'h4);
        tick(); drive(1'b1, 16'h0010, 4'h0, 32'h0); settle();
        chk("ramr_busy",  32'(dmem_busy), 32'h0);
        chk("ramr_ramWe", 32'(ram_we),    32'h0);
        tick(); drive(1'b0, 16'h0000, 4'h0, 32'h0); settle();
        chk("ramr_data",  dmem_data,      32'h12345678);
        chk("idle_ramE",  32'(ram_e),     32'h0);

        // Bus read, ack at N+3
        tick(); drive(1'b1, 16'h8004, 4'h0, 32'h0); settle();
        chk("bus_N_busy", 32'(dmem_busy), 32'h1);
        chk("bus_N_ramE", 32'(ram_e),     32'h0);
        tick(); settle();
        chk("bus_N1_busy", 32'(dmem_busy),         32'h1);
        chk("bus_N1_req",  32'(bus_if.O_busReq),   32'h1);
        chk("bus_N1_addr", 32'(bus_if.O_busAddr),  32'h0004);
        chk("bus_N1_we",   32'(bus_if.O_busWe),    32'h0);
        tick(); settle();
        chk("bus_N2_busy", 32'(dmem_busy), 32'h1);
        tick(); bus_if.I_busAck = 1'b1; bus_if.I_busRData = 32'hCAFEF00D; settle();
        chk("bus_N3_busy", 32'(dmem_busy), 32'h0);
        tick(); bus_if.I_busAck = 1'b0; drive(1'b0, 16'h0000, 4'h0, 32'h0); settle();
        chk("bus_N4_req",  32'(bus_if.O_busReq), 32'h0);
        chk("bus_N4_data", dmem_data,            32'hCAFEF00D);

        // Bus write acked at N+1, then RAM read
        tick(); drive(1'b1, 16'h8000, 4'hF, 32'hA5A50001); settle();
        chk("bw_N_busy", 32'(dmem_busy), 32'h1);
        tick(); bus_if.I_busAck = 1'b1; bus_if.I_busRData = 32'h11112222; settle();
        chk("bw_N1_busy",  32'(dmem_busy),       32'h0);
        chk("bw_N1_req",   32'(bus_if.O_busReq), 32'h1);
        chk("bw_N1_we",    32'(bus_if.O_busWe),  32'hF);
        chk("bw_N1_wdata", bus_if.O_busWData,    32'hA5A50001);
        tick(); bus_if.I_busAck = 1'b0; drive(1'b1, 16'h0010, 4'h0, 32'h0); settle();
        chk("bw_N2_req",  32'(bus_if.O_busReq), 32'h0);
        chk("bw_N2_busy", 32'(dmem_busy),       32'h0);
        chk("bw_N2_data", dmem_data,            32'h11112222);
        tick(); drive(1'b0, 16'h0000, 4'h0, 32'h0); settle();
        chk("bw_N3_ramsel", dmem_data, 32'h12345678);

        // Back-to-back bus reads: new hit in RESP
        tick(); drive(1'b1, 16'h8008, 4'h0, 32'h0); settle();
        tick(); bus_if.I_busAck = 1'b1; bus_if.I_busRData = 32'h0BAD0001; settle();
        chk("b2b_ack1_busy", 32'(dmem_busy), 32'h0);
        tick(); bus_if.I_busAck = 1'b0; drive(1'b1, 16'h800C, 4'h0, 32'h0); settle();
        chk("b2b_resp_busy", 32'(dmem_busy),       32'h1);
        chk("b2b_resp_req",  32'(bus_if.O_busReq), 32'h0);
        chk("b2b_resp_data", dmem_data,            32'h0BAD0001);
        tick(); bus_if.I_busAck = 1'b1; bus_if.I_busRData = 32'h0BAD0002; settle();
        chk("b2b_req2",  32'(bus_if.O_busReq),  32'h1);
        chk("b2b_addr2", 32'(bus_if.O_busAddr), 32'h000C);
        chk("b2b_busy2", 32'(dmem_busy),        32'h0);
        tick(); bus_if.I_busAck = 1'b0; drive(1'b0, 16'h0000, 4'h0, 32'h0); settle();
        chk("b2b_data2", dmem_data, 32'h0BAD0002);

        // Ack outside WAIT is ignored
        tick(); bus_if.I_busAck = 1'b1; bus_if.I_busRData = 32'h99999999; settle();
        chk("stray_busy", 32'(dmem_busy), 32'h0);
        tick(); bus_if.I_busAck = 1'b0; settle();
        chk("stray_req",  32'(bus_if.O_busReq), 32'h0);
        chk("stray_data", dmem_data,            32'h0BAD0002);

`ifdef CEESPU_DMEM_TIMEOUT_EN
        // Timeout with TIMEOUT_CYCLES=4
        tick(); drive(1'b1, 16'h8020, 4'h0, 32'h0); settle();
        chk("to_N_busy", 32'(dmem_busy), 32'h1);
        for (int i = 0; i < 4; i++) begin
            tick(); settle();
            chk("to_wait_busy", 32'(dmem_busy), 32'h1);
        end
        tick(); settle();
        chk("to_exp_busy", 32'(dmem_busy),       32'h0);
        chk("to_exp_err",  32'(bus_if.O_busErr), 32'h0);
        tick(); drive(1'b0, 16'h0000, 4'h0, 32'h0); settle();
        chk("to_data", dmem_data,               32'hDEADBEEF);
        chk("to_err",  32'(bus_if.O_busErr),    32'h1);
        chk("to_req",  32'(bus_if.O_busReq),    32'h0);
        tick(); tick(); settle();
        chk("to_err_held", 32'(bus_if.O_busErr), 32'h1);
`else
        chk("err_tied", 32'(bus_if.O_busErr), 32'h0);
`endif

        // Reset asserted two cycles into a bus access
        tick(); drive(1'b1, 16'h8010, 4'h0, 32'h0); settle();
        tick(); settle();
        chk("rw_req", 32'(bus_if.O_busReq), 32'h1);
        tick(); rst = 1'b1; drive(1'b0, 16'h0000, 4'h0, 32'h0);
        #1;
        chk("rw_req_async", 32'(bus_if.O_busReq),  32'h0);
        chk("rw_addr",      32'(bus_if.O_busAddr), 32'h0);
        chk("rw_busy",      32'(dmem_busy),        32'h0);
        chk("rw_err",       32'(bus_if.O_busErr),  32'h0);
        tick(); rst = 1'b0;
        tick(); bus_if.I_busAck = 1'b1; bus_if.I_busRData = 32'h77777777; settle();
        chk("rw_late_busy", 32'(dmem_busy), 32'h0);
        tick(); bus_if.I_busAck = 1'b0; settle();
        chk("rw_late_req",  32'(bus_if.O_busReq), 32'h0);
        chk("rw_late_data", dmem_data,            32'h12345678);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached, observed running expected finished");
        $fatal(1, "watchdog expired");
    end

endmodule
